// File: rtl/mem_block_copier.sv
// Word-copy engine that drives the unified memory port (we, a, wd, rd).
// Copies len 32-bit words from src to dst, one read then one write per word, overlap-safe.
module mem_block_copier #(
  parameter int LENW      = 16,
  parameter int MEM_WORDS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     src,
  input  logic [31:0]     dst,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            we,
  output logic [31:0]     a,
  output logic [31:0]     wd,
  input  logic [31:0]     rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

  state_t          state_q;
  logic [31:0]     src_cur_q, dst_cur_q;
  logic [31:0]     a_q, wd_q;
  logic [LENW-1:0] cnt_q;
  logic            desc_q, busy_q, done_q, err_q, we_q;

  logic [32:0]     src_end_d, dst_end_d;
  logic [33:0]     src_lim_d;
  logic [31:0]     last_off_d, src_nxt_d, dst_nxt_d;
  logic            misalign_d, range_bad_d, overlap_d;

  // End-of-block word indices are formed one bit wider so huge addresses cannot wrap past the check.
  assign src_end_d   = {3'b000, src[31:2]} + 33'(len);
  assign dst_end_d   = {3'b000, dst[31:2]} + 33'(len);
  assign misalign_d  = (|src[1:0]) | (|dst[1:0]);
  assign range_bad_d = (src_end_d > 33'(MEM_WORDS)) || (dst_end_d > 33'(MEM_WORDS));

  assign src_lim_d   = {2'b00, src} + 34'({len, 2'b00});
  assign overlap_d   = (dst > src) && ({2'b00, dst} < src_lim_d);
  assign last_off_d  = 32'({len - LENW'(1), 2'b00});

  assign src_nxt_d   = desc_q ? (src_cur_q - 32'd4) : (src_cur_q + 32'd4);
  assign dst_nxt_d   = desc_q ? (dst_cur_q - 32'd4) : (dst_cur_q + 32'd4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      src_cur_q <= '0;
      dst_cur_q <= '0;
      a_q       <= '0;
      wd_q      <= '0;
      cnt_q     <= '0;
      desc_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (start) begin
            if (misalign_d || range_bad_d) begin
              err_q <= 1'b1;
            end else if (len == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              // Destination above an overlapping source: copy from the top down.
              state_q   <= READ;
              busy_q    <= 1'b1;
              desc_q    <= overlap_d;
              cnt_q     <= len;
              src_cur_q <= overlap_d ? (src + last_off_d) : src;
              dst_cur_q <= overlap_d ? (dst + last_off_d) : dst;
              a_q       <= overlap_d ? (src + last_off_d) : src;
            end
          end
        end
        READ: begin
          state_q <= WRITE;
          wd_q    <= rd;
          we_q    <= 1'b1;
          a_q     <= dst_cur_q;
        end
        WRITE: begin
          src_cur_q <= src_nxt_d;
          dst_cur_q <= dst_nxt_d;
          cnt_q     <= cnt_q - LENW'(1);
          we_q      <= 1'b0;
          wd_q      <= '0;
          if (cnt_q == LENW'(1)) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            a_q     <= '0;
          end else begin
            state_q <= READ;
            a_q     <= src_nxt_d;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with reset keeps an in-flight write from landing on a reset edge.
  assign we   = we_q & reset;
  assign a    = a_q;
  assign wd   = wd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
